// File: rtl/clashup_loader.sv
// clashup_loader: program loader for the ClashUp CPU.
// Receives a framed image (SYNC, LEN, LEN payload bytes, CSUM) over a
// valid/ready byte stream, writes the payload into program RAM, and releases
// the CPU from reset only once the checksum verifies.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_data   byte stream from the host link
//   in_ready            loader accepts a byte this cycle (registered)
//   ram_we/addr/wdata   program RAM write port (registered)
//   cpu_rst             CPU reset, high whenever no verified image runs
//   done                verified image loaded, CPU running
//   err                 last frame rejected, cleared by the next sync byte
module clashup_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hC1,
  parameter bit         CLEAR_RAM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       cpu_rst,
  output logic       done,
  output logic       err
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [DW-1:0] len, len_d;
  logic [DW-1:0] sum, sum_d;
  logic          ready_d, we_d, cpu_rst_d, done_d, err_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          accept_c;

  // A byte is consumed only when the registered ready meets valid.
  assign accept_c = in_valid && in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    len_d     = len;
    sum_d     = sum;
    we_d      = 1'b0;
    addr_d    = ram_addr;
    wdata_d   = ram_wdata;
    cpu_rst_d = cpu_rst;
    done_d    = done;
    err_d     = err;

    case (state)
      S_IDLE, S_RUN: begin
        // Sync byte starts a (re)load; everything else is discarded.
        if (accept_c && in_data == SYNC_BYTE) begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          if (CLEAR_RAM) begin
            state_d = S_CLEAR;
            idx_d   = '0;
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            state_d = S_LEN;
          end
        end
      end

      S_CLEAR: begin
        // idx is the address being written this cycle; 255 is the last one.
        if (idx == '1) begin
          state_d = S_LEN;
        end else begin
          idx_d   = idx + AW'(1);
          we_d    = 1'b1;
          addr_d  = idx + AW'(1);
          wdata_d = '0;
        end
      end

      S_LEN: begin
        if (accept_c) begin
          if (in_data == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = in_data;
            idx_d   = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept_c) begin
          we_d    = 1'b1;
          addr_d  = idx;
          wdata_d = in_data;
          idx_d   = idx + AW'(1);
          sum_d   = sum + in_data;
          if (idx == len - DW'(1)) state_d = S_CSUM;
        end
      end

      S_CSUM: begin
        if (accept_c) begin
          if (in_data == sum) begin
            state_d   = S_RUN;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ready follows the state we are entering, so it is valid next cycle.
    ready_d = (state_d != S_CLEAR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      len       <= '0;
      sum       <= '0;
      in_ready  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      len       <= len_d;
      sum       <= sum_d;
      in_ready  <= ready_d;
      ram_we    <= we_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      cpu_rst   <= cpu_rst_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_clashup_loader.sv
// Testbench for clashup_loader: one instance without RAM clear, one with.
// Frames are driven byte by byte; expected writes, status and RAM image are
// derived from the frame contents by a simple behavioural model.
module tb_clashup_loader;

  localparam logic [7:0] SYNC = 8'hC1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       r0, we0, cr0, dn0, e0;
  logic       r1, we1, cr1, dn1, e1;
  logic [7:0] a0, wd0, a1, wd1;

  clashup_loader #(.SYNC_BYTE(SYNC), .CLEAR_RAM(1'b0)) u_noclr (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .ram_we(we0), .ram_addr(a0), .ram_wdata(wd0), .cpu_rst(cr0),
    .done(dn0), .err(e0)
  );

  clashup_loader #(.SYNC_BYTE(SYNC), .CLEAR_RAM(1'b1)) u_clr (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .ram_we(we1), .ram_addr(a1), .ram_wdata(wd1), .cpu_rst(cr1),
    .done(dn1), .err(e1)
  );

  // Selected instance under test (0: no clear, 1: clear).
  bit         sel = 1'b0;
  logic       o_ready, o_we, o_cpu_rst, o_done, o_err;
  logic [7:0] o_addr, o_wdata;
  assign o_ready   = sel ? r1  : r0;
  assign o_we      = sel ? we1 : we0;
  assign o_addr    = sel ? a1  : a0;
  assign o_wdata   = sel ? wd1 : wd0;
  assign o_cpu_rst = sel ? cr1 : cr0;
  assign o_done    = sel ? dn1 : dn0;
  assign o_err     = sel ? e1  : e0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: log of writes plus a shadow of each instance's RAM.
  int         wq_cyc[$];
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];
  logic [7:0] dut_mem[2][256];
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(o_addr);
      wq_data.push_back(o_wdata);
      dut_mem[sel][o_addr] <= o_wdata;
    end
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] pay[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin v1 = v; d1 = d; end
    else     begin v0 = v; d0 = d; end
  endtask

  task automatic clear_log();
    wq_cyc.delete();
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Offer one byte after an optional random gap; stamp = cycle it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max, output int stamp, output int waited);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, 32'(gap_max))) : 0;
    repeat (g) begin
      drive(1'b0, 8'($urandom));
      step();
    end
    drive(1'b1, b);
    waited = 0;
    while (o_ready !== 1'b1 && waited < 1000) begin
      step();
      waited++;
    end
    if (waited >= 1000) check("ready_timeout", 32'(o_ready), 32'd1);
    step();
    stamp = cyc;
    drive(1'b0, b);
  endtask

  function automatic int payload_sum(input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(pay[i]);
    return s % 256;
  endfunction

  // Send a full frame and check status, write stream and resulting RAM image.
  task automatic load_frame(input int len, input logic [7:0] csum, input int gap_max);
    bit clr;
    bit good;
    int st, w, sync_st, base, bad, k;
    int stamps[256];
    logic [7:0] expv;
    clr = sel;
    clear_log();
    send_byte(SYNC, gap_max, sync_st, w);
    check("sync_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("sync_done", 32'(o_done), 32'd0);
    check("sync_err", 32'(o_err), 32'd0);
    send_byte(8'(len), clr ? 0 : gap_max, st, w);
    if (clr) check("clear_stall_cycles", 32'(w), 32'd256);
    if (len == 0) begin
      check("len0_err", 32'(o_err), 32'd1);
      check("len0_cpu_rst", 32'(o_cpu_rst), 32'd1);
      check("len0_writes", 32'(wq_addr.size()), clr ? 32'd256 : 32'd0);
      return;
    end
    for (int i = 0; i < len; i++) send_byte(pay[i], gap_max, stamps[i], w);
    check("pre_csum_cpu_rst", 32'(o_cpu_rst), 32'd1);
    good = (int'(csum) == payload_sum(len));
    send_byte(csum, gap_max, st, w);
    check("csum_cpu_rst", 32'(o_cpu_rst), good ? 32'd0 : 32'd1);
    check("csum_done", 32'(o_done), good ? 32'd1 : 32'd0);
    check("csum_err", 32'(o_err), good ? 32'd0 : 32'd1);
    base = clr ? 256 : 0;
    check("write_count", 32'(wq_addr.size()), 32'(base + len));
    if (clr) begin
      bad = 0;
      for (int a = 0; a < 256; a++) begin
        if (a >= wq_addr.size()) bad++;
        else if (int'(wq_addr[a]) != a || wq_data[a] != 8'h00 || wq_cyc[a] != sync_st + a) bad++;
      end
      check("clear_writes", 32'(bad), 32'd0);
    end
    for (int i = 0; i < len; i++) begin
      k = base + i;
      if (k < wq_addr.size()) begin
        check("wr_addr", 32'(wq_addr[k]), 32'(i));
        check("wr_data", 32'(wq_data[k]), 32'(pay[i]));
        check("wr_cycle", 32'(wq_cyc[k]), 32'(stamps[i]));
      end
    end
    if (good) begin
      bad = 0;
      for (int a = 0; a < 256; a++) begin
        expv = (a < len) ? pay[a] : 8'h00;
        if ((a < len || clr) && dut_mem[sel][a] !== expv) bad++;
      end
      check("ram_image", 32'(bad), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   32'(o_ready),   32'd0);
    check({tag, "_we"},      32'(o_we),      32'd0);
    check({tag, "_addr"},    32'(o_addr),    32'd0);
    check({tag, "_wdata"},   32'(o_wdata),   32'd0);
    check({tag, "_cpu_rst"}, 32'(o_cpu_rst), 32'd1);
    check({tag, "_done"},    32'(o_done),    32'd0);
    check({tag, "_err"},     32'(o_err),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, w, len, s, nwr;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;

    // Reset values, then ready on the second cycle after release.
    repeat (3) step();
    rst = 1'b0;
    sel = 1'b0; check_reset_values("rst0");
    sel = 1'b1; check_reset_values("rst1");
    step();
    check("ready_after_rst1", 32'(o_ready), 32'd1);
    sel = 1'b0;
    check("ready_after_rst0", 32'(o_ready), 32'd1);

    // No clear: C1 03 01 00 05 06 streamed back to back.
    pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'h05;
    load_frame(3, 8'h06, 0);
    // Same frame with a bad checksum (hot reload from RUN).
    load_frame(3, 8'h07, 0);
    // Zero length frame; the sync also clears the previous err.
    load_frame(0, 8'h00, 0);

    // Clear: C1 02 AA BB 65.
    sel = 1'b1;
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    load_frame(2, 8'h65, 0);
    // Non-sync byte in RUN is ignored.
    nwr = wq_addr.size();
    send_byte(8'h7E, 0, st, w);
    step();
    check("run_noise_done", 32'(o_done), 32'd1);
    check("run_noise_cpu_rst", 32'(o_cpu_rst), 32'd0);
    check("run_noise_writes", 32'(wq_addr.size()), 32'(nwr));
    // Hot reload C1 01 FF FF.
    pay[0] = 8'hFF;
    load_frame(1, 8'hFF, 0);

    // Full 255-byte frame with random valid gaps.
    sel = 1'b0;
    for (int i = 0; i < 255; i++) pay[i] = 8'($urandom);
    load_frame(255, 8'(payload_sum(255)), 3);

    // Reset after the 2nd payload byte of a 4-byte frame.
    clear_log();
    send_byte(SYNC, 0, st, w);
    send_byte(8'd4, 0, st, w);
    send_byte(8'h11, 0, st, w);
    send_byte(8'h22, 0, st, w);
    drive(1'b1, 8'h33);
    rst = 1'b1;
    step();
    check_reset_values("midrst");
    step();
    step();
    rst = 1'b0;
    check("midrst_ready_hold", 32'(o_ready), 32'd0);
    drive(1'b0, 8'h00);
    step();
    check("midrst_ready_up", 32'(o_ready), 32'd1);
    check("midrst_writes", 32'(wq_addr.size()), 32'd2);
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    load_frame(4, 8'(payload_sum(4)), 1);
    sel = 1'b1;
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    load_frame(3, 8'(payload_sum(3)), 0);

    // Random frames on both instances, including sync values in the payload.
    for (int f = 0; f < 10; f++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'($urandom_range(0, 8'hC0)), 2, st, w);
      end
      len = (f == 4) ? 0 : int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      if (len > 0 && $urandom_range(0, 1) == 1) pay[$urandom_range(0, 32'(len - 1))] = SYNC;
      s = payload_sum(len);
      if ($urandom_range(0, 2) == 0) s = (s + int'($urandom_range(1, 255))) % 256;
      load_frame(len, 8'(s), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clashup_loader.md
# clashup_loader

Program loader for the ClashUp CPU. It receives a framed bytecode image over a valid/ready byte stream and writes it into the CPU program RAM through a write port. It holds the CPU in reset while loading and releases it only after the frame checksum verifies. It sits between the host link (UART/SPI byte receiver) and the CPU's `ram` write side and `rst` input.

## Interface

Parameters:
- `SYNC_BYTE`, default 8'hC1: frame start marker.
- `CLEAR_RAM`, default 1: if 1, zero all 256 RAM locations before writing payload.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `in_valid`, input, 1: `in_data` holds a byte.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: loader accepts a byte this cycle. Registered.
- `ram_we`, output, 1: RAM write strobe.
- `ram_addr`, output, 8: RAM write address.
- `ram_wdata`, output, 8: RAM write data.
- `cpu_rst`, output, 1: reset to CPU. High whenever no verified image is running.
- `done`, output, 1: verified image loaded and CPU running.
- `err`, output, 1: last frame rejected. Sticky until the next `SYNC_BYTE` is accepted.

## Operation

- Frame format: `SYNC_BYTE`, then `LEN` (1..255), then LEN payload bytes, then `CSUM`.
- `CSUM` is the sum of the payload bytes mod 256.
- Payload byte i is written to address i, for i = 0..LEN-1. Addresses LEN..255 are not written, except by CLEAR.
- Accept rule: a byte is consumed only in a cycle with `in_valid && in_ready`. `in_valid` gaps of any length are legal.
- States and transitions:
  - IDLE: `in_ready`=1. A non-sync byte is discarded. A sync byte goes to CLEAR if `CLEAR_RAM`=1, else to LEN; it also clears `err`.
  - CLEAR: `in_ready`=0. Writes 8'h00 to addresses 0..255, one per cycle, for 256 cycles. Then goes to LEN.
  - LEN: accepts one byte.
    - 0: set `err`, go to IDLE.
    - Otherwise: store LEN, clear index and running sum, go to DATA.
  - DATA: each accepted byte is written to `ram_addr`=index, index increments and the running sum accumulates (8-bit wrap). After the LEN-th byte, go to CSUM.
  - CSUM: accepts one byte.
    - Equal to running sum: go to RUN.
    - Otherwise: set `err` and go to IDLE. RAM contents are undefined, but `cpu_rst` stays high.
  - RUN: `cpu_rst`=0, `done`=1, `in_ready`=1. Non-sync bytes are discarded. A sync byte reasserts `cpu_rst`, drops `done`, clears `err`, and enters CLEAR or LEN as from IDLE (hot reload).
- The payload is not interpreted; any byte value, including values equal to `SYNC_BYTE`, is legal inside LEN/DATA/CSUM.

## Timing

- Reset values, held during and on the first cycle after `rst`: state IDLE, `in_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0. `in_ready` rises on the second cycle after `rst` falls.
- `rst` mid-frame or mid-CLEAR aborts immediately to IDLE with the values above. No further writes are issued.
- All outputs are registered. `in_ready` reflects the next state, so it is 0 in the first CLEAR cycle and returns to 1 in the first LEN cycle. No byte is accepted during CLEAR.
- Write latency: a data byte accepted at cycle t produces `ram_we`=1 with its addr/data at cycle t+1, for exactly one cycle.
- CLEAR: `ram_we`=1 for exactly 256 consecutive cycles, `ram_addr` 0..255, `ram_wdata` 0. It starts the cycle after the sync byte is accepted.
- A CSUM match accepted at cycle t gives `cpu_rst`=0 and `done`=1 at t+1. The last payload write is at or before t, so the CPU never fetches before the write completes.
- A CSUM mismatch accepted at cycle t gives `err`=1 at t+1.
- A hot-reload sync accepted at t gives `cpu_rst`=1 and `done`=0 at t+1.
- Sustained throughput: one byte per cycle in LEN/DATA/CSUM/IDLE/RUN.

## Test plan

- `CLEAR_RAM`=0; stream C1 03 01 00 05 06, `in_valid` held high -> writes (0,01),(1,00),(2,05) on consecutive cycles; `cpu_rst` falls and `done` rises the cycle after 06 is accepted; `err`=0.
- Same frame with CSUM 07 -> no RUN; `err`=1 the cycle after; `cpu_rst` stays 1; a following C1 clears `err`.
- `CLEAR_RAM`=1; C1 then 02 AA BB 65 offered continuously -> `in_ready`=0 for exactly 256 cycles with zero writes to 00..FF; then writes (0,AA),(1,BB); RUN.
- In RUN, send 7E (discarded, `done` stays 1), then C1 01 FF FF -> `cpu_rst` high the cycle after C1; reload; RUN again with ram[0]=FF.
- Frame C1 00 -> `err`=1, back to IDLE, no writes. Random `in_valid` gaps on a valid 255-byte frame -> 255 writes at addresses 0..FE, checksum match, RUN.
- Assert `rst` after the 2nd payload byte of a 4-byte frame -> no further `ram_we`; all outputs at reset values; the next full frame loads correctly.
